knn_ctrl: RTL and testbench

Sequencer for the KNN distance/list datapath. On start, it walks every test point against every data point and issues one memory read per pair. It drives the core's distance-enable and list-insert strobes, clears the K-nearest list between test points, and hands each finished test point to the consumer through a valid/ready handshake. It sits between the CPU register interface and the knn_core datapath.

---
 rtl/knn_ctrl.sv | 141 ++++++++++++++
 tb/tb_knn_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/knn_ctrl.sv
// Sequencer for the KNN distance/list datapath: walks every test point against
// every data point, strobes the core one cycle behind each read, and hands results out.
module knn_ctrl #(
  parameter int NBR_TESTP = 4,
  parameter int NBR_DATAP = 10,
  parameter int NBR_KNN   = 4,
  parameter int IDX_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] testp_idx,
  output logic [IDX_W-1:0] datap_idx,
  output logic             list_clr,
  output logic             en_dist,
  output logic             list_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_testp,
  output logic [7:0]       res_k,
  output logic [2:0]       dbg_state
);

  // Result handshake: a transfer happens only in a cycle where res_valid and
  // res_ready are both high; res_valid/res_testp hold steady until then, and
  // res_ready is ignored whenever res_valid is low.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FETCH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_REPORT = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] T_LAST  = IDX_W'(NBR_TESTP - 1);
  localparam logic [IDX_W-1:0] D_LAST  = IDX_W'(NBR_DATAP - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] t_q, t_nxt;
  logic [IDX_W-1:0] d_q, d_nxt;
  logic             p_q, p_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      t_q   <= '0;
      d_q   <= '0;
      p_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      t_q   <= t_nxt;
      d_q   <= d_nxt;
      p_q   <= p_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t_q;
    d_nxt     = d_q;
    mem_rd_en = 1'b0;
    testp_idx = '0;
    datap_idx = '0;
    list_clr  = 1'b0;
    res_valid = 1'b0;
    res_testp = '0;
    done      = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          t_nxt     = '0;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        list_clr  = 1'b1;
        d_nxt     = '0;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        testp_idx = t_q;
        datap_idx = d_q;
        if (d_q == D_LAST) begin
          d_nxt     = '0;
          state_nxt = S_DRAIN;
        end else begin
          d_nxt = d_q + IDX_ONE;
        end
      end
      S_DRAIN: begin
        state_nxt = S_REPORT;
      end
      S_REPORT: begin
        res_valid = 1'b1;
        res_testp = t_q;
        if (res_ready) begin
          if (t_q == T_LAST) begin
            state_nxt = S_FIN;
          end else begin
            t_nxt     = t_q + IDX_ONE;
            state_nxt = S_CLEAR;
          end
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Abort wins over everything; counters are left alone since the next start
    // and the next CLEAR reinitialise them.
    if (abort && (state != S_IDLE)) begin
      state_nxt = S_IDLE;
      t_nxt     = t_q;
      d_nxt     = d_q;
    end
  end

  // Read latency is one cycle, so the core strobes simply trail mem_rd_en.
  assign p_nxt      = abort ? 1'b0 : mem_rd_en;
  assign en_dist    = p_q;
  assign list_valid = p_q;

  assign busy      = (state != S_IDLE);
  assign res_k     = 8'(NBR_KNN);
  assign dbg_state = state;

endmodule

// File: tb/tb_knn_ctrl.sv
// Randomized bench for knn_ctrl: builds the expected per-cycle output trace of
// each run from the sequencing rules, then drives the inputs and compares.
module tb_knn_ctrl;

  localparam int W    = 31;
  localparam int A_NT = 2;
  localparam int A_ND = 3;
  localparam int B_NT = 1;
  localparam int B_ND = 1;

  logic clk;
  logic rst;

  logic start_a, abort_a, ready_a;
  logic busy_a, done_a, rd_a, clr_a, en_a, lv_a, rv_a;
  logic [7:0] tidx_a, didx_a, rt_a, resk_a;
  logic [2:0] dbg_a;

  logic start_b, abort_b, ready_b;
  logic busy_b, done_b, rd_b, clr_b, en_b, lv_b, rv_b;
  logic [7:0] tidx_b, didx_b, rt_b, resk_b;
  logic [2:0] dbg_b;

  logic [W-1:0] obs_a, obs_b;
  logic [W-1:0] exp_q[$];
  logic [2:0]   in_q[$];

  int n_vec;
  int n_fail;

  knn_ctrl #(.NBR_TESTP(A_NT), .NBR_DATAP(A_ND), .NBR_KNN(4), .IDX_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .mem_rd_en(rd_a),
    .testp_idx(tidx_a), .datap_idx(didx_a), .list_clr(clr_a),
    .en_dist(en_a), .list_valid(lv_a), .res_valid(rv_a),
    .res_ready(ready_a), .res_testp(rt_a), .res_k(resk_a), .dbg_state(dbg_a)
  );

  knn_ctrl #(.NBR_TESTP(B_NT), .NBR_DATAP(B_ND), .NBR_KNN(3), .IDX_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .mem_rd_en(rd_b),
    .testp_idx(tidx_b), .datap_idx(didx_b), .list_clr(clr_b),
    .en_dist(en_b), .list_valid(lv_b), .res_valid(rv_b),
    .res_ready(ready_b), .res_testp(rt_b), .res_k(resk_b), .dbg_state(dbg_b)
  );

  assign obs_a = {busy_a, done_a, rd_a, clr_a, en_a, lv_a, rv_a, tidx_a, didx_a, rt_a};
  assign obs_b = {busy_b, done_b, rd_b, clr_b, en_b, lv_b, rv_b, tidx_b, didx_b, rt_b};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output word: {busy, done, rd, clr, en_dist, list_valid, res_valid, tidx, didx, rtestp}
  function automatic logic [W-1:0] mk(input bit busy, input bit done, input bit rd,
                                      input bit clr, input bit strobe, input bit rv,
                                      input int ti, input int di, input int rt);
    return {busy, done, rd, clr, strobe, strobe, rv, 8'(ti), 8'(di), 8'(rt)};
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit rnd_start();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic push(input logic [W-1:0] v, input logic [2:0] iv);
    exp_q.push_back(v);
    in_q.push_back(iv);
  endtask

  // Reference trace of one run. stall_mode: 0 none, 1 five-cycle stall in the
  // first report, 2 random stalls. abort_at: -1 none, 0 random cycle, >0 fixed cycle.
  task automatic build(input int nt, input int nd, input int stall_mode, input int abort_at);
    int s;
    int a;
    exp_q.delete();
    in_q.delete();
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), {1'b1, 1'b0, rnd_bit()});
    for (int t = 0; t < nt; t++) begin
      push(mk(1, 0, 0, 1, 0, 0, 0, 0, 0), {rnd_start(), 1'b0, rnd_bit()});
      for (int d = 0; d < nd; d++)
        push(mk(1, 0, 1, 0, d > 0, 0, t, d, 0), {rnd_start(), 1'b0, rnd_bit()});
      push(mk(1, 0, 0, 0, 1, 0, 0, 0, 0), {rnd_start(), 1'b0, rnd_bit()});
      s = (stall_mode == 1 && t == 0) ? 5 : (stall_mode == 2) ? $urandom_range(0, 3) : 0;
      repeat (s) push(mk(1, 0, 0, 0, 0, 1, 0, 0, t), {rnd_start(), 1'b0, 1'b0});
      push(mk(1, 0, 0, 0, 0, 1, 0, 0, t), {rnd_start(), 1'b0, 1'b1});
    end
    push(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), {rnd_start(), 1'b0, rnd_bit()});
    if (abort_at >= 0) begin
      a = (abort_at > 0) ? abort_at : $urandom_range(1, exp_q.size() - 2);
      in_q[a][1] = 1'b1;
      while (exp_q.size() > a + 1) begin
        void'(exp_q.pop_back());
        void'(in_q.pop_back());
      end
    end
    repeat (3) push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), {1'b0, 1'b0, rnd_bit()});
  endtask

  // driver tasks
  task automatic drive(input bit sel, input logic [2:0] iv);
    if (sel) {start_b, abort_b, ready_b} = iv;
    else     {start_a, abort_a, ready_a} = iv;
  endtask

  task automatic run(input bit sel, input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1 drive(sel, in_q[i]);
      @(negedge clk);
      check($sformatf("%s_cyc%0d", name, i), sel ? obs_b : obs_a, exp_q[i]);
    end
    @(posedge clk);
    #1 drive(sel, 3'b000);
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    rst = 1'b0;
    {start_a, abort_a, ready_a} = 3'b000;
    {start_b, abort_b, ready_b} = 3'b000;
    #2;
    check("reset_a", obs_a, '0);
    check("reset_b", obs_b, '0);
    check("res_k_a", resk_a, 8'd4);
    check("res_k_b", resk_b, 8'd3);
    @(posedge clk);
    #1 rst = 1'b1;

    build(A_NT, A_ND, 0, -1); run(1'b0, "basic");
    build(A_NT, A_ND, 1, -1); run(1'b0, "stall5");
    build(A_NT, A_ND, 0, 3);  run(1'b0, "abort3");
    build(A_NT, A_ND, 0, -1); run(1'b0, "rerun");
    build(B_NT, B_ND, 0, -1); run(1'b1, "single");

    // asynchronous reset in the middle of FETCH
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_fetch", obs_a, mk(1, 0, 1, 0, 1, 0, 0, 1, 0));
    rst = 1'b0;
    #1 check("async_rst", obs_a, '0);
    @(posedge clk); #1 rst = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_a%0d", i), obs_a, '0);
      check($sformatf("post_rst_b%0d", i), obs_b, '0);
    end
    @(posedge clk); #1;
    ready_a = 1'b0;
    ready_b = 1'b0;

    for (int k = 0; k < 20; k++) begin
      build(A_NT, A_ND, 2, ($urandom_range(0, 2) == 0) ? 0 : -1);
      run(1'b0, $sformatf("rand_a%0d", k));
    end
    for (int k = 0; k < 8; k++) begin
      build(B_NT, B_ND, 2, ($urandom_range(0, 2) == 0) ? 0 : -1);
      run(1'b1, $sformatf("rand_b%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
